cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller between the pipelined 16-bit core's L1 caches (instruction and data) and the multi-cycle main memory. On a cache miss it fetches the 8-word (16-byte) block containing the miss address, drives one data-array write per returned word and one tag-array write with the final word, then releases the pipeline stall. One instance is used per cache, with the shared memory arbitrated externally.

## Interface
- BLOCK_WORDS, 8: words per cache block; power of two.
- ADDR_W, 16: byte-address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  16  byte address of the missing access; valid with miss_detected.
- fsm_busy  out  1  stall to the pipeline: high for the whole miss service, including the detecting cycle.
- memory_request  out  1  read request to main memory; one word per cycle.
- memory_address  out  16  byte address of the requested word; valid with memory_request.
- memory_data_valid  in  1  main memory returns one word this cycle; words return in request order.
- memory_data  in  16  returned word.
- write_data_array  out  1  write fill_data into the cache data array at fill_word_idx.
- write_tag_array  out  1  write the tag/valid bit for the block; asserted with the final data write.
- fill_word_idx  out  3  word offset within the block for the current data-array write.
- fill_data  out  16  combinational pass-through of memory_data.

## Operation
- States: IDLE, FILL.
- IDLE: fsm_busy = miss_detected (combinational). If miss_detected, latch base = miss_address with bits [3:0] cleared, clear issue_cnt and recv_cnt, go to FILL.
- FILL: fsm_busy = 1.
  - Issue: memory_request = 1 while issue_cnt < BLOCK_WORDS. memory_address = base + 2*issue_cnt. issue_cnt increments each cycle and saturates at BLOCK_WORDS.
  - Receive: on memory_data_valid, write_data_array = 1, fill_word_idx = recv_cnt[2:0], and recv_cnt increments.
  - When memory_data_valid and recv_cnt == BLOCK_WORDS-1: also assert write_tag_array and go to IDLE on the next edge.
- Address arithmetic is 16-bit; a block never crosses the top of the address space because the base is aligned, so there is no wrap.
- The block makes no assumption about memory latency, only that words return in order.

## Timing
- Reset (asynchronous, rst_n = 0): state = IDLE, counters = 0, base = 0. Outputs while in reset: every output is 0 except fill_data, which follows memory_data.
- With 4-cycle memory (valid 3 cycles after the request edge), miss detected in cycle 0:
  - requests in cycles 1–8;
  - data writes in cycles 4–11;
  - tag write in cycle 11;
  - fsm_busy is high in cycles 0–11 and low in cycle 12.
- miss_detected during FILL is ignored.
- memory_data_valid in IDLE is ignored: no writes.
- Back-to-back misses: a new miss can be accepted in the first IDLE cycle after a fill.
- Reset mid-fill: abort immediately. No further writes; no tag write. Outstanding memory returns after reset are ignored (state is IDLE).
- Request and receive in the same cycle are independent; both occur.

## Structure
- Shared package cache_pkg holds:
  - the state typedef (IDLE, FILL);
  - BLOCK_BYTES = 16;
  - OFFSET_W = 4;
  - WORD_IDX_W = 3.
- One sub-module, fill_counter: 4-bit counter with synchronous clear, enable, and saturation at BLOCK_WORDS, and asynchronous reset. Instantiated twice, for issue_cnt and recv_cnt.

## Test plan
- Miss at 0x1236, 4-cycle memory:
  - requests to 0x1230, 0x1232, … 0x123E on consecutive cycles;
  - 8 data writes with idx 0..7;
  - write_tag_array only on idx 7;
  - fsm_busy high for exactly 12 cycles.
- Memory with irregular valid gaps (returns spread over 20 cycles): idx still 0..7 in order, tag write on the 8th valid, busy drops the cycle after.
- miss_detected held high throughout the fill with a different address (0x4000): ignored; next fill starts only after IDLE and targets 0x4000.
- rst_n pulsed low after the 3rd data write:
  - all outputs 0 asynchronously;
  - no tag write;
  - later valids are ignored;
  - a subsequent miss at 0x0000 fills cleanly.
- memory_data_valid pulses while IDLE: no write_data_array or write_tag_array.
- Back-to-back misses (0x0010, then 0xFFF0 the cycle after IDLE): second fill addresses 0xFFF0–0xFFFE with no wrap.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the L1 miss-fill controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_W    = 4;
    localparam int WORD_IDX_W  = 3;
    // One extra bit so the counters can hold BLOCK_WORDS itself as "done".
    localparam int CNT_W       = WORD_IDX_W + 1;

endpackage

// File: rtl/fill_counter.sv
// Word counter for a block fill: synchronous clear, enable, saturates at MAX.
module fill_counter
    import cache_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// L1 miss handler: fetches the aligned block containing the miss address,
// writes each returned word into the data array and the tag with the last word.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    output logic                  fsm_busy,
    output logic                  memory_request,
    output logic [ADDR_W-1:0]     memory_address,
    input  logic                  memory_data_valid,
    input  logic [15:0]           memory_data,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [WORD_IDX_W-1:0] fill_word_idx,
    output logic [15:0]           fill_data
);

    localparam logic [CNT_W-1:0]  WORDS      = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              in_fill;
    logic              start;
    logic              issuing;
    logic              receiving;
    logic              last_word;

    assign in_fill   = (state == FILL);
    assign start     = (state == IDLE) && miss_detected;
    assign issuing   = in_fill && (issue_cnt < WORDS);
    assign receiving = in_fill && memory_data_valid;
    assign last_word = receiving && (recv_cnt == LAST_WORD);

    fill_counter #(.MAX(BLOCK_WORDS)) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .enable (issuing),
        .count  (issue_cnt)
    );

    fill_counter #(.MAX(BLOCK_WORDS)) u_recv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .enable (receiving),
        .count  (recv_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state <= FILL;
                        base  <= miss_address & BLOCK_MASK;
                    end
                end
                FILL: begin
                    if (last_word) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // The stall follows miss_detected combinationally, so gate it with reset
    // to keep every control output quiet while rst_n is held low.
    assign fsm_busy         = rst_n && (in_fill || start);
    assign memory_request   = issuing;
    assign memory_address   = issuing ? (base + ADDR_W'({issue_cnt, 1'b0})) : '0;
    assign write_data_array = receiving;
    assign write_tag_array  = last_word;
    assign fill_word_idx    = receiving ? recv_cnt[WORD_IDX_W-1:0] : '0;
    assign fill_data        = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a driver plays miss/memory traffic and
// queues the expected requests, writes and stall; a monitor pops and compares.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        memory_request;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_request    (memory_request),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word_idx     (fill_word_idx),
        .fill_data         (fill_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } req_t;

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        tag;
    } wr_t;

    req_t exp_req[$];
    wr_t  exp_wr[$];
    logic exp_busy[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: one stall value per cycle, plus request and write events.
    req_t r;
    wr_t  w;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_busy.size() == 0) fail("busy_unscheduled", fsm_busy);
            else check("fsm_busy", fsm_busy, exp_busy.pop_front());

            if (memory_request) begin
                if (exp_req.size() == 0) begin
                    fail("unexpected_request", memory_address);
                end else begin
                    r = exp_req.pop_front();
                    check("req_addr", memory_address, r.addr);
                    check("req_cycle", cyc, r.cyc);
                end
            end

            if (write_data_array) begin
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write", fill_word_idx);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_idx", fill_word_idx, w.idx);
                    check("wr_data", fill_data, w.data);
                    check("wr_tag", write_tag_array, w.tag);
                    check("wr_cycle", cyc, w.cyc);
                end
            end else if (write_tag_array) begin
                fail("tag_without_data", write_tag_array);
            end
        end
    end

    task automatic check_all_quiet(input string tag);
        check({tag, "_busy"}, fsm_busy, 0);
        check({tag, "_req"}, memory_request, 0);
        check({tag, "_addr"}, memory_address, 0);
        check({tag, "_wda"}, write_data_array, 0);
        check({tag, "_wta"}, write_tag_array, 0);
        check({tag, "_idx"}, fill_word_idx, 0);
        check({tag, "_fill_data"}, fill_data, memory_data);
    endtask

    task automatic idle_cycles(input int n, input bit pulse_valid);
        for (int i = 0; i < n; i++) begin
            miss_detected     = 1'b0;
            miss_address      = 16'($urandom);
            memory_data_valid = pulse_valid && (i % 2 == 0);
            memory_data       = 16'($urandom);
            exp_busy.push_back(1'b0);
            @(posedge clk); #1;
        end
    endtask

    // One miss service. Word k is requested at t=k+1; returns follow a
    // fixed 4-cycle latency or random gaps. abort_after>0 resets after that
    // many returned words.
    task automatic run_fill(input logic [15:0] addr, input bit irregular,
                            input bit hold, input logic [15:0] hold_addr,
                            input int abort_after);
        int          vt[8];
        int          k = 0;
        int          t = 0;
        logic [15:0] base;
        base  = addr & 16'hFFF0;
        vt[0] = irregular ? 3 + int'($urandom_range(0, 2)) : 4;
        for (int i = 1; i < 8; i++)
            vt[i] = vt[i-1] + (irregular ? 1 + int'($urandom_range(0, 2)) : 1);
        while (k < 8) begin
            if (t == 0) begin
                miss_detected = 1'b1;
                miss_address  = addr;
            end else if (hold) begin
                miss_detected = 1'b1;
                miss_address  = hold_addr;
            end else begin
                miss_detected = 1'($urandom);
                miss_address  = 16'($urandom);
            end
            if (t >= 1 && t <= 8) exp_req.push_back('{cyc, base + 16'(2 * (t - 1))});
            memory_data_valid = (t == vt[k]);
            memory_data       = 16'($urandom);
            if (memory_data_valid) begin
                exp_wr.push_back('{cyc, 3'(k), memory_data, (k == 7)});
                k++;
            end
            exp_busy.push_back(1'b1);
            if (abort_after != 0 && k == abort_after) begin
                @(negedge clk); #2;
                rst_n = 1'b0;
                #1;
                check_all_quiet("abort");
                for (int i = 0; i < 2; i++) begin
                    @(posedge clk); #1;
                    miss_detected     = 1'($urandom);
                    memory_data_valid = 1'b1;
                    memory_data       = 16'($urandom);
                    exp_busy.push_back(1'b0);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            t++;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data       = 16'hA5A5;
        #3;
        check_all_quiet("reset");
        miss_detected = 1'b1;
        #1;
        check("reset_busy_gated", fsm_busy, 0);
        miss_detected = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        idle_cycles(2, 1'b0);
        run_fill(16'h1236, 1'b0, 1'b0, 16'h0000, 0);
        idle_cycles(4, 1'b1);
        for (int i = 0; i < 3; i++) run_fill(16'($urandom), 1'b1, 1'b0, 16'h0000, 0);
        idle_cycles(1, 1'b0);
        run_fill(16'h2468, 1'b0, 1'b1, 16'h4000, 0);
        run_fill(16'h4000, 1'b1, 1'b0, 16'h0000, 0);
        idle_cycles(2, 1'b0);
        run_fill(16'h8A5C, 1'b0, 1'b0, 16'h0000, 3);
        idle_cycles(4, 1'b1);
        run_fill(16'h0000, 1'b0, 1'b0, 16'h0000, 0);
        run_fill(16'h0010, 1'b0, 1'b0, 16'h0000, 0);
        run_fill(16'hFFF0, 1'b0, 1'b0, 16'h0000, 0);
        idle_cycles(3, 1'b1);
        mon_en = 1'b0;

        check("req_queue_drained", exp_req.size(), 0);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("busy_queue_drained", exp_busy.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
